// File: rtl/axibram_rdata_buf_if.sv
// axibram_rdata_buf_if: AXI read-data channel bundle around the R output buffer.
// Carries the upstream beat stream (s_*) from the BRAM read engine and the
// registered downstream R channel towards the PS GP0 port.
//   slave  : view of the buffer itself
//   master : view of the producer/consumer surrounding the buffer
interface axibram_rdata_buf_if #(
    parameter int DATA_BITS = 32,
    parameter int ID_BITS   = 12
);
    logic [DATA_BITS-1:0] s_rdata;
    logic [ID_BITS-1:0]   s_rid;
    logic [1:0]           s_rresp;
    logic                 s_rlast;
    logic                 s_rvalid;
    logic                 s_rready;

    logic [DATA_BITS-1:0] rdata;
    logic [ID_BITS-1:0]   rid;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport slave (
        input  s_rdata, s_rid, s_rresp, s_rlast, s_rvalid, rready,
        output s_rready, rdata, rid, rresp, rlast, rvalid
    );

    modport master (
        output s_rdata, s_rid, s_rresp, s_rlast, s_rvalid, rready,
        input  s_rready, rdata, rid, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axibram_rdata_buf.sv
// axibram_rdata_buf: registered R-channel output stage.
// Head register drives the AXI outputs; a (DEPTH-1)-entry circular array sits
// behind it. s_rready is a flop computed from next fill level, so rready never
// reaches the upstream engine combinationally.
// Optional burst framing checker: define AXIBRAM_RDBUF_CHK_EN.
module axibram_rdata_buf #(
    parameter int DEPTH_BITS = 2,
    parameter int DATA_BITS  = 32,
    parameter int ID_BITS    = 12
) (
    input  logic                  aclk,
    input  logic                  rst,
    axibram_rdata_buf_if.slave    bus,
    output logic [DEPTH_BITS:0]   level,
    output logic [1:0]            err
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int AD    = (DEPTH > 1) ? DEPTH - 1 : 1;
    localparam int PW    = (DEPTH_BITS > 0) ? DEPTH_BITS : 1;
    localparam int W     = DATA_BITS + ID_BITS + 3;
    localparam int LW    = DEPTH_BITS + 1;

    logic [W-1:0]  mem [AD];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  in_word;
    logic          push, pop, head_load, arr_empty, arr_wr, arr_rd;
    logic [LW-1:0] arr_cnt, level_next;

    // Array pointers wrap over DEPTH-1 entries, not a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(AD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_word    = {bus.s_rdata, bus.s_rid, bus.s_rresp, bus.s_rlast};
    assign push       = bus.s_rvalid && bus.s_rready;
    assign pop        = bus.rvalid && bus.rready;
    assign head_load  = !bus.rvalid || bus.rready;
    assign arr_cnt    = level - LW'(bus.rvalid);
    assign arr_empty  = (arr_cnt == '0);
    // Head refills from the array first; a push only bypasses into the head
    // when nothing older is waiting.
    assign arr_rd     = head_load && !arr_empty;
    assign arr_wr     = push && !(head_load && arr_empty);
    assign level_next = level + LW'(push) - LW'(pop);

    // Head register: all AXI-facing outputs come straight from these flops.
    always_ff @(posedge aclk) begin
        if (rst) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.rid    <= '0;
            bus.rresp  <= '0;
            bus.rlast  <= 1'b0;
        end else if (head_load) begin
            if (!arr_empty) begin
                {bus.rdata, bus.rid, bus.rresp, bus.rlast} <= mem[rd_ptr];
                bus.rvalid <= 1'b1;
            end else if (push) begin
                {bus.rdata, bus.rid, bus.rresp, bus.rlast} <= in_word;
                bus.rvalid <= 1'b1;
            end else begin
                bus.rvalid <= 1'b0;
            end
        end
    end

    // Array storage; contents are don't-care until written, so no reset.
    always_ff @(posedge aclk) begin
        if (!rst && arr_wr)
            mem[wr_ptr] <= in_word;
    end

    // Array pointers.
    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (arr_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (arr_rd) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Fill level and registered upstream ready.
    always_ff @(posedge aclk) begin
        if (rst) begin
            level        <= '0;
            bus.s_rready <= 1'b0;
        end else begin
            level        <= level_next;
            bus.s_rready <= (level_next < LW'(DEPTH));
        end
    end

`ifdef AXIBRAM_RDBUF_CHK_EN
    logic [4:0]         bcnt;
    logic [ID_BITS-1:0] bid;

    // Burst framing checker: observes pushes only, never touches data flow.
    always_ff @(posedge aclk) begin
        if (rst) begin
            bcnt <= '0;
            bid  <= '0;
            err  <= 2'b00;
        end else if (push) begin
            if (bcnt == 5'd0)
                bid <= bus.s_rid;
            else if (bus.s_rid != bid)
                err[1] <= 1'b1;
            if (!bus.s_rlast && bcnt >= 5'd16)
                err[0] <= 1'b1;
            if (bus.s_rlast)
                bcnt <= '0;
            else if (bcnt != 5'd31)
                bcnt <= bcnt + 5'd1;
        end
    end
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_axibram_rdata_buf.sv
// tb_axibram_rdata_buf: directed + randomized bench for axibram_rdata_buf
// (DEPTH_BITS=2) against a queue-based model of the buffer.
module tb_axibram_rdata_buf;
    localparam int DB    = 2;
    localparam int DEPTH = 1 << DB;
`ifdef AXIBRAM_RDBUF_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          rst  = 1'b1;
    logic [DB:0]   level;
    logic [1:0]    err;

    axibram_rdata_buf_if #(.DATA_BITS(32), .ID_BITS(12)) bus ();

    axibram_rdata_buf #(.DEPTH_BITS(DB), .DATA_BITS(32), .ID_BITS(12)) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus),
        .level(level),
        .err  (err)
    );

    always #5 aclk = ~aclk;

    // model state
    logic [46:0] q[$];
    logic [46:0] last;
    logic        m_rdy;
    logic [1:0]  m_err;
    int          bcnt;
    logic [11:0] fid;
    logic        pushed;
    int          maxlvl;

    // stimulus source state
    int          checks, errors;
    int          sent, limit, src_len;
    logic [31:0] src_base;
    logic [11:0] src_id;
    logic        vld;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [46:0] hexp;
        hexp = (q.size() > 0) ? q[0] : last;
        chk("rvalid", 64'(bus.rvalid), 64'(q.size() > 0));
        chk("level", 64'(level), 64'(q.size()));
        chk("s_rready", 64'(bus.s_rready), 64'(m_rdy));
        chk("head", 64'({bus.rdata, bus.rid, bus.rresp, bus.rlast}), 64'(hexp));
        chk("err", 64'(err), 64'(m_err));
    endtask

    // One clock: decide handshakes from the model, advance model, compare.
    task automatic step();
        logic        psh, pp;
        logic [46:0] w;
        psh = !rst && bus.s_rvalid && m_rdy;
        pp  = !rst && (q.size() > 0) && bus.rready;
        w   = {bus.s_rdata, bus.s_rid, bus.s_rresp, bus.s_rlast};
        @(posedge aclk);
        #1;
        pushed = psh;
        if (rst) begin
            q.delete();
            last  = '0;
            m_rdy = 1'b0;
            m_err = 2'b00;
            bcnt  = 0;
            fid   = '0;
        end else begin
            if (pp) last = q.pop_front();
            if (psh) begin
                q.push_back(w);
                if (CHK) begin
                    if (bcnt == 0) fid = bus.s_rid;
                    else if (bus.s_rid != fid) m_err[1] = 1'b1;
                    if (!bus.s_rlast && bcnt >= 16) m_err[0] = 1'b1;
                    bcnt = bus.s_rlast ? 0 : bcnt + 1;
                end
            end
            m_rdy = (q.size() < DEPTH);
        end
        if (int'(level) > maxlvl) maxlvl = int'(level);
        check_all();
    endtask

    // rmode: 0 hold low, 1 hold high, 2 toggle, 3 random. Producer holds a
    // beat until it is accepted and stops after 'limit' beats.
    task automatic run(input int n, input int rmode, input bit rnd_vld);
        for (int c = 0; c < n; c++) begin
            case (rmode)
                0: bus.rready = 1'b0;
                1: bus.rready = 1'b1;
                2: bus.rready = (c % 2 == 0);
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            if (!vld)
                vld = (sent < limit) && (!rnd_vld || $urandom_range(0, 3) != 0);
            bus.s_rvalid = vld;
            bus.s_rdata  = src_base + 32'(sent);
            bus.s_rid    = src_id;
            bus.s_rresp  = 2'((src_base + 32'(sent)) >> 1);
            bus.s_rlast  = (src_len != 0) && (sent % src_len == src_len - 1);
            step();
            if (pushed) begin
                sent++;
                vld = 1'b0;
            end
        end
        bus.s_rvalid = vld;
    endtask

    task automatic new_src(input logic [11:0] id, input logic [31:0] base, input int len, input int lim);
        src_id = id; src_base = base; src_len = len; sent = 0; limit = lim;
    endtask

    initial begin
        checks = 0; errors = 0; vld = 1'b0; maxlvl = 0;
        q.delete(); last = '0; m_rdy = 1'b0; m_err = 2'b00; bcnt = 0; fid = '0;
        bus.s_rvalid = 1'b0; bus.s_rdata = '0; bus.s_rid = '0;
        bus.s_rresp = '0; bus.s_rlast = 1'b0; bus.rready = 1'b0;
        new_src(12'h0, 32'h0, 4, 0);

        // reset state
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 4-beat burst, rready high: level must stay at most 1
        maxlvl = 0;
        new_src(12'h123, 32'd1, 4, 4);
        run(8, 1, 1'b0);
        chk("t1_maxlvl", 64'(maxlvl), 64'd1);

        // rready low, continuous upstream: exactly DEPTH beats absorbed
        new_src(12'h045, 32'h100, 4, 100);
        run(8, 0, 1'b0);
        chk("t2_accepted", 64'(sent), 64'(DEPTH));
        limit = sent;
        run(6, 1, 1'b0);

        // 16-beat burst with rready toggling every cycle
        new_src(12'h7AB, 32'h200, 16, 16);
        run(40, 2, 1'b0);
        chk("t3_sent", 64'(sent), 64'd16);

        // random traffic
        new_src(12'h3C3, 32'h1000, 8, 1000);
        run(300, 3, 1'b1);
        limit = sent;
        run(10, 1, 1'b0);

        // reset while holding 3 beats, then a fresh beat 0xA5
        new_src(12'h011, 32'h300, 4, 3);
        run(5, 0, 1'b0);
        chk("t4_level3", 64'(level), 64'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        new_src(12'h022, 32'hA5, 1, 1);
        run(4, 1, 1'b0);

        // framing: 17 beats without rlast, then an 18th closing the burst
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        new_src(12'h055, 32'h400, 18, 17);
        run(20, 1, 1'b0);
        chk("t5_err_long", 64'(err), CHK ? 64'd1 : 64'd0);
        limit = 18;
        run(4, 1, 1'b0);
        // new burst whose ID changes on beat 2
        new_src(12'h0A1, 32'h500, 2, 1);
        run(2, 1, 1'b0);
        src_id = 12'h0B2;
        limit  = 2;
        run(4, 1, 1'b0);
        chk("t5_err_id", 64'(err), CHK ? 64'd3 : 64'd0);
        run(3, 1, 1'b0);
        rst = 1'b1;
        step();
        chk("t5_err_rst", 64'(err), 64'd0);
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
